// File: rtl/pulse_scheduler_mc.sv
// Multi-channel timed pulse scheduler: per-channel FIFOs of timestamped pulse
// instructions, released against a free-running timebase while in RUN.
module pulse_scheduler_mc #(
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 8,
   parameter int TIME_W = 32
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [TIME_W+31:0]                      pulse_inst_in,
   input  logic                                    pulse_inst_in_valid,
   output logic                                    pulse_inst_in_ready,
   input  logic                                    start,
   input  logic                                    stop,
   input  logic                                    flush,
   input  logic                                    err_clr,
   output logic [TIME_W-1:0]                       counter,
   output logic                                    running,
   output logic [NUM_CH-1:0]                       pulse_fire,
   output logic [NUM_CH*12-1:0]                    pulse_freq,
   output logic [NUM_CH*8-1:0]                     pulse_phase,
   output logic [NUM_CH*8-1:0]                     pulse_amp,
   output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]     occupancy,
   output logic [NUM_CH-1:0]                       err_late,
   output logic                                    err_chan
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam int EW = TIME_W + 28;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]        state;
   logic [3:0]        in_ch;
   logic [EW-1:0]     in_entry;
   logic [15:0]       full_pad;
   logic [NUM_CH-1:0] full;
   logic              chan_bad;
   logic              accept;

   // Queue entry layout: {t_start, freq, phase, amp}
   assign in_ch    = pulse_inst_in[3:0];
   assign in_entry = {pulse_inst_in[TIME_W+31:32], pulse_inst_in[15:4],
                      pulse_inst_in[23:16], pulse_inst_in[31:24]};
   assign chan_bad = ({1'b0, in_ch} >= 5'(NUM_CH));
   assign pulse_inst_in_ready = !flush && (chan_bad || !full_pad[in_ch]);
   assign accept   = pulse_inst_in_valid && pulse_inst_in_ready;
   assign running  = (state == RUN);

   for (genvar gi = 0; gi < 16; gi++) begin : g_full
      if (gi < NUM_CH) begin : g_used
         assign full_pad[gi] = full[gi];
      end else begin : g_unused
         assign full_pad[gi] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         counter <= '0;
      end else if (state == IDLE) begin
         if (start && !stop) begin
            state   <= RUN;
            counter <= '0;
         end
      end else begin
         counter <= counter + 1'b1;
         if (stop) state <= IDLE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    err_chan <= 1'b0;
      else if (accept && chan_bad) err_chan <= 1'b1;
      else if (err_clr)           err_chan <= 1'b0;
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [EW-1:0]     mem [DEPTH];
      logic [AW-1:0]     rd_ptr;
      logic [AW-1:0]     wr_ptr;
      logic [OW-1:0]     count;
      logic [EW-1:0]     head;
      logic [TIME_W-1:0] d;
      logic              has_head;
      logic              push_now;
      logic              fire_now;
      logic              late_now;
      logic              pop_now;
      logic              fire_reg;
      logic              late_reg;
      logic [11:0]       freq_reg;
      logic [7:0]        phase_reg;
      logic [7:0]        amp_reg;

      // Head is read asynchronously so an entry is comparable the cycle after its push.
      assign head     = mem[rd_ptr];
      assign has_head = (count != '0);
      assign d        = head[EW-1 -: TIME_W] - counter;
      assign full[gi] = (count == OW'(DEPTH));
      assign push_now = accept && !chan_bad && (in_ch == 4'(gi));
      assign fire_now = running && has_head && (d == '0) && !flush;
      assign late_now = running && has_head && d[TIME_W-1] && !flush;
      assign pop_now  = fire_now || late_now;

      always_ff @(posedge clk) begin
         if (push_now) mem[wr_ptr] <= in_entry;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_now) wr_ptr <= wr_ptr + 1'b1;
            if (pop_now)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_now, pop_now})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            fire_reg  <= 1'b0;
            late_reg  <= 1'b0;
            freq_reg  <= '0;
            phase_reg <= '0;
            amp_reg   <= '0;
         end else begin
            fire_reg <= fire_now;
            if (fire_now) begin
               freq_reg  <= head[27:16];
               phase_reg <= head[15:8];
               amp_reg   <= head[7:0];
            end
            if (late_now)     late_reg <= 1'b1;
            else if (err_clr) late_reg <= 1'b0;
         end
      end

      assign pulse_fire[gi]            = fire_reg;
      assign err_late[gi]              = late_reg;
      assign pulse_freq[gi*12 +: 12]   = freq_reg;
      assign pulse_phase[gi*8 +: 8]    = phase_reg;
      assign pulse_amp[gi*8 +: 8]      = amp_reg;
      assign occupancy[gi*OW +: OW]    = count;
   end
endmodule

// File: tb/tb_pulse_scheduler_mc.sv
// Scoreboard bench for pulse_scheduler_mc with an 8-bit timebase so the wrap case is reachable.
module tb_pulse_scheduler_mc;
   localparam int NUM_CH = 4;
   localparam int DEPTH  = 8;
   localparam int TIME_W = 8;
   localparam int OW     = $clog2(DEPTH) + 1;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [TIME_W+31:0]       pulse_inst_in = '0;
   logic                     pulse_inst_in_valid = 1'b0;
   logic                     pulse_inst_in_ready;
   logic                     start = 1'b0;
   logic                     stop = 1'b0;
   logic                     flush = 1'b0;
   logic                     err_clr = 1'b0;
   logic [TIME_W-1:0]        counter;
   logic                     running;
   logic [NUM_CH-1:0]        pulse_fire;
   logic [NUM_CH*12-1:0]     pulse_freq;
   logic [NUM_CH*8-1:0]      pulse_phase;
   logic [NUM_CH*8-1:0]      pulse_amp;
   logic [NUM_CH*OW-1:0]     occupancy;
   logic [NUM_CH-1:0]        err_late;
   logic                     err_chan;

   typedef struct {
      int         ch;
      logic [7:0] cnt;
      logic [11:0] freq;
      logic [7:0] phase;
      logic [7:0] amp;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [7:0] c0;

   pulse_scheduler_mc #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TIME_W(TIME_W)) dut (
      .clk(clk), .rst(rst),
      .pulse_inst_in(pulse_inst_in), .pulse_inst_in_valid(pulse_inst_in_valid),
      .pulse_inst_in_ready(pulse_inst_in_ready),
      .start(start), .stop(stop), .flush(flush), .err_clr(err_clr),
      .counter(counter), .running(running), .pulse_fire(pulse_fire),
      .pulse_freq(pulse_freq), .pulse_phase(pulse_phase), .pulse_amp(pulse_amp),
      .occupancy(occupancy), .err_late(err_late), .err_chan(err_chan)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic int occ(input int c);
      return int'(occupancy[c*OW +: OW]);
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch, input logic [7:0] t, input logic [11:0] f,
                       input logic [7:0] ph, input logic [7:0] a, input bit expect_fire);
      pulse_inst_in       = {t, a, ph, f, 4'(ch)};
      pulse_inst_in_valid = 1'b1;
      #1;
      check($sformatf("ready_ch%0d", ch), pulse_inst_in_ready, 1'b1);
      if (expect_fire)
         exp_q.push_back('{ch: ch, cnt: t + 8'd1, freq: f, phase: ph, amp: a});
      $display("push ch%0d t_start=%0d at counter=%0d", ch, t, counter);
      @(posedge clk);
      #1;
      pulse_inst_in_valid = 1'b0;
   endtask

   task automatic wait_counter(input logic [7:0] v, input int bound);
      int n = 0;
      while (counter !== v && n < bound) begin
         tick();
         n++;
      end
      check("wait_counter", counter, v);
   endtask

   task automatic wait_drain(input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         tick();
         n++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   // Each observed fire must match the oldest outstanding expectation for its channel.
   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (pulse_fire[c]) begin
               int idx;
               idx = -1;
               foreach (exp_q[i]) if (idx < 0 && exp_q[i].ch == c) idx = i;
               $display("fire ch%0d at counter=%0d", c, counter);
               if (idx < 0) begin
                  check($sformatf("unexpected_fire_ch%0d", c), pulse_fire[c], 1'b0);
               end else begin
                  check($sformatf("fire_cnt_ch%0d", c), counter, exp_q[idx].cnt);
                  check($sformatf("fire_freq_ch%0d", c), pulse_freq[c*12 +: 12], exp_q[idx].freq);
                  check($sformatf("fire_phase_ch%0d", c), pulse_phase[c*8 +: 8], exp_q[idx].phase);
                  check($sformatf("fire_amp_ch%0d", c), pulse_amp[c*8 +: 8], exp_q[idx].amp);
                  exp_q.delete(idx);
               end
            end
         end
      end
   end

   initial begin
      tick(3);
      check("rst_counter", counter, 0);
      check("rst_running", running, 0);
      check("rst_occ", occupancy, 0);
      check("rst_fire", pulse_fire, 0);
      check("rst_err", {err_late, err_chan}, 0);
      check("rst_ready", pulse_inst_in_ready, 1'b1);
      rst = 1'b0;

      // basic fire
      push(1, 8'd10, 12'h5A5, 8'h33, 8'hC7, 1);
      check("occ_ch1", occ(1), 1);
      start = 1'b1; tick(); start = 1'b0;
      check("running", running, 1'b1);
      wait_drain(40);
      check("fire_one_cycle", pulse_fire, 0);
      check("hold_amp_ch1", pulse_amp[15:8], 8'hC7);

      // late drop
      wait_counter(8'd20, 40);
      push(0, 8'd5, 12'h111, 8'h22, 8'h44, 0);
      tick();
      check("late_err", err_late, 4'b0001);
      check("late_occ", occ(0), 0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("late_clr", err_late, 0);

      // backpressure
      stop = 1'b1; tick(); stop = 1'b0;
      check("stopped", running, 1'b0);
      for (int i = 0; i < DEPTH; i++)
         push(2, 8'(30 + 2*i), 12'(i*16 + 1), 8'(i), 8'(i + 100), 1);
      check("occ_ch2_full", occ(2), DEPTH);
      pulse_inst_in = {8'd60, 8'd0, 8'd0, 12'd0, 4'd2};
      #1;
      check("ready_ch2_full", pulse_inst_in_ready, 1'b0);
      push(3, 8'd60, 12'h333, 8'h03, 8'h30, 1);
      pulse_inst_in = {8'd60, 8'd0, 8'd0, 12'd0, 4'd2};
      start = 1'b1; tick(); start = 1'b0;
      for (int n = 0; n < 60 && occ(2) == DEPTH; n++) tick();
      check("occ_ch2_after_fire", occ(2), DEPTH - 1);
      check("ready_ch2_after_fire", pulse_inst_in_ready, 1'b1);
      wait_drain(100);

      // simultaneous fires and bad channel
      stop = 1'b1; tick(); stop = 1'b0;
      push(0, 8'd7, 12'hA0A, 8'h5A, 8'h0F, 1);
      push(3, 8'd7, 12'h0B0, 8'hA5, 8'hF0, 1);
      push(15, 8'd7, 12'hFFF, 8'hFF, 8'hFF, 0);
      check("err_chan_set", err_chan, 1'b1);
      start = 1'b1; tick(); start = 1'b0;
      wait_drain(30);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("err_chan_clr", err_chan, 1'b0);

      // timebase wrap
      wait_counter(8'd250, 300);
      push(1, 8'd3, 12'h7E7, 8'h81, 8'h42, 1);
      wait_drain(30);
      check("wrap_no_late", err_late, 0);

      // flush
      push(0, 8'(counter + 60), 12'h001, 8'h01, 8'h01, 0);
      push(1, 8'(counter + 70), 12'h002, 8'h02, 8'h02, 0);
      check("occ_pre_flush", occ(0) + occ(1), 2);
      flush = 1'b1;
      #1;
      check("ready_flush", pulse_inst_in_ready, 1'b0);
      c0 = counter;
      tick();
      flush = 1'b0;
      check("flush_occ", occupancy, 0);
      check("flush_counter", counter, 8'(c0 + 1));
      check("flush_running", running, 1'b1);
      tick(5);

      // async reset mid-RUN
      push(9, 8'd0, 12'h0, 8'h0, 8'h0, 0);
      push(3, 8'(counter - 10), 12'h004, 8'h04, 8'h04, 0);
      push(2, 8'(counter + 40), 12'h005, 8'h05, 8'h05, 0);
      check("pre_rst_err", {err_late[3], err_chan}, 2'b11);
      #2 rst = 1'b1;
      #1;
      check("arst_counter", counter, 0);
      check("arst_running", running, 0);
      check("arst_occ", occupancy, 0);
      check("arst_fire", pulse_fire, 0);
      check("arst_freq", pulse_freq, 0);
      check("arst_phase", pulse_phase, 0);
      check("arst_amp", pulse_amp, 0);
      check("arst_err", {err_late, err_chan}, 0);
      check("arst_ready", pulse_inst_in_ready, 1'b1);
      tick(2);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
